// File: rtl/mda_attr_sequencer.sv
// mda_attr_sequencer: MDA pixel decode, frame blink timing and vsync-committed phosphor scheme select.
module mda_attr_sequencer #(
   parameter int FRAME_W    = 5,
   parameter int CURSOR_BIT = 3,
   parameter int CHAR_BIT   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_valid,
   input  logic               char_pix,
   input  logic [7:0]         attr,
   input  logic               underline_row,
   input  logic               cursor_hit,
   input  logic               display_en,
   input  logic               blink_en,
   input  logic               vsync,
   input  logic               cfg_wr,
   input  logic [2:0]         cfg_rgb,
   output logic               cfg_busy,
   output logic               cfg_ack,
   output logic               cfg_err,
   output logic [2:0]         mda_rgb,
   output logic               video,
   output logic               intensity,
   output logic [FRAME_W-1:0] frame_cnt
);
   typedef enum logic {IDLE, PEND} state_t;
   state_t state_q, state_d;
   logic vs_q, vs_rise, wr_ok, commit, cur_ph, chr_ph, fg;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [2:0] pend_q, pend_d, rgb_q, rgb_d;
   logic ack_q, ack_d, err_q, err_d, video_q, video_d, int_q, int_d;
   logic [7:0] am;

   assign vs_rise = vsync & ~vs_q;
   assign wr_ok   = cfg_wr & (cfg_rgb <= 3'd2);
   assign commit  = (state_q == PEND) & vs_rise;
   assign cur_ph  = frame_q[CURSOR_BIT];
   assign chr_ph  = frame_q[CHAR_BIT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // A write landing on the commit edge keeps the FSM pending for the next frame.
   always_comb begin
      state_d = (state_q == IDLE) ? (wr_ok ? PEND : IDLE) : ((vs_rise & ~wr_ok) ? IDLE : PEND);
   end

   always_comb begin
      am      = attr & 8'h77;
      frame_d = vs_rise ? frame_q + FRAME_W'(1) : frame_q;
      pend_d  = wr_ok ? cfg_rgb : pend_q;
      rgb_d   = commit ? pend_q : rgb_q;
      ack_d   = commit;
      err_d   = cfg_wr & ~wr_ok;
      fg      = (char_pix | ((attr[2:0] == 3'b001) & underline_row)) & ~(blink_en & attr[7] & ~chr_ph);
      video_d = 1'b0;
      int_d   = 1'b0;
      if (!pix_valid || !display_en) begin
         video_d = 1'b0;
      end else if (cursor_hit && cur_ph) begin
         video_d = 1'b1;
      end else if (am == 8'h00) begin
         video_d = 1'b0;
      end else if (am == 8'h70) begin
         video_d = ~char_pix;
         int_d   = ~char_pix & attr[7] & ~blink_en;
      end else begin
         video_d = fg;
         int_d   = fg & attr[3];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q    <= 1'b0;
         frame_q <= '0;
         pend_q  <= 3'd0;
         rgb_q   <= 3'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         video_q <= 1'b0;
         int_q   <= 1'b0;
      end else begin
         vs_q    <= vsync;
         frame_q <= frame_d;
         pend_q  <= pend_d;
         rgb_q   <= rgb_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         video_q <= video_d;
         int_q   <= int_d;
      end
   end

   assign cfg_busy  = (state_q == PEND);
   assign cfg_ack   = ack_q;
   assign cfg_err   = err_q;
   assign mda_rgb   = rgb_q;
   assign video     = video_q;
   assign intensity = int_q;
   assign frame_cnt = frame_q;
endmodule
